// File: rtl/ps2_scancode_ctrl.sv
// PS/2 scan-code sequencer: E0/F0 prefix tracking, system-byte pulse, FWFT event FIFO.
// Optional autorepeat suppression is built when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_scancode_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    keycode_i,
  input  logic                          keycode_valid_i,
  input  logic                          flush_i,
  input  logic                          evt_ready_i,
  output logic                          evt_valid_o,
  output logic [9:0]                    evt_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count_o,
  output logic                          sys_valid_o,
  output logic [7:0]                    sys_code_o,
  output logic                          overflow_o,
  output logic                          seq_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } state_t;

  function automatic logic is_sys_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_sys_byte = 1'b1;
      default:                                          is_sys_byte = 1'b0;
    endcase
  endfunction

  state_t          state_r, state_nxt_s;
  logic [TW-1:0]   tmo_cnt_r;
  logic            byte_s, is_sys_s, is_pfx_s, timeout_s;
  logic            push_req_s, push_ext_s, push_rel_s, push_s;
  logic            seq_err_set_s, sys_hit_s;
  logic            pop_s, full_s, wr_en_s, ovf_set_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [9:0]      mem_r [FIFO_DEPTH];
  logic            seq_err_r, overflow_r, sys_valid_r;
  logic [7:0]      sys_code_r;

  // A flushed byte never reaches the sequencer; a live byte always beats the timeout.
  assign byte_s    = keycode_valid_i && !flush_i;
  assign is_sys_s  = is_sys_byte(keycode_i);
  assign is_pfx_s  = (keycode_i == 8'hE0) || (keycode_i == 8'hF0);
  assign timeout_s = (state_r != ST_IDLE) && !keycode_valid_i && !flush_i && (tmo_cnt_r == TMO_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else if (byte_s) begin
      if (is_sys_s) begin
        state_nxt_s = ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: state_nxt_s = (keycode_i == 8'hE0) ? ST_E0 :
                                 (keycode_i == 8'hF0) ? ST_F0 : ST_IDLE;
          ST_E0:   state_nxt_s = (keycode_i == 8'hE0) ? ST_E0 :
                                 (keycode_i == 8'hF0) ? ST_E0F0 : ST_IDLE;
          ST_F0:   state_nxt_s = ST_IDLE;
          ST_E0F0: state_nxt_s = ST_IDLE;
          default: state_nxt_s = ST_IDLE;
        endcase
      end
    end else if (timeout_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: event push request, error and system-byte strobes
  always_comb begin
    push_req_s    = 1'b0;
    push_ext_s    = 1'b0;
    push_rel_s    = 1'b0;
    seq_err_set_s = 1'b0;
    sys_hit_s     = 1'b0;
    if (byte_s) begin
      if (is_sys_s) begin
        sys_hit_s     = 1'b1;
        seq_err_set_s = (state_r != ST_IDLE);
      end else begin
        case (state_r)
          ST_IDLE: push_req_s = !is_pfx_s;
          ST_E0: begin
            push_req_s = !is_pfx_s;
            push_ext_s = 1'b1;
          end
          ST_F0: begin
            push_req_s    = !is_pfx_s;
            push_rel_s    = 1'b1;
            seq_err_set_s = is_pfx_s;
          end
          ST_E0F0: begin
            push_req_s    = !is_pfx_s;
            push_ext_s    = 1'b1;
            push_rel_s    = 1'b1;
            seq_err_set_s = is_pfx_s;
          end
          default: push_req_s = 1'b0;
        endcase
      end
    end else begin
      seq_err_set_s = timeout_s;
    end
  end

  // Inter-byte timeout counter, only meaningful while a prefix is pending
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt_r <= '0;
    end else if (flush_i || keycode_valid_i || timeout_s || (state_r == ST_IDLE)) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_r;
  logic [8:0] last_key_r;
  logic       same_key_s;

  assign same_key_s = (last_key_r == {push_ext_s, keycode_i});
  assign push_s     = push_req_s && !(!push_rel_s && held_r && same_key_s);

  // Last make key tracker for autorepeat suppression
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      held_r     <= 1'b0;
      last_key_r <= 9'h000;
    end else if (flush_i) begin
      held_r     <= 1'b0;
    end else if (push_req_s && push_rel_s && same_key_s) begin
      held_r     <= 1'b0;
    end else if (push_req_s && !push_rel_s && !(held_r && same_key_s)) begin
      held_r     <= 1'b1;
      last_key_r <= {push_ext_s, keycode_i};
    end else begin
      held_r     <= held_r;
    end
  end
`else
  assign push_s = push_req_s;
`endif

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop_s     = (count_r != '0) && evt_ready_i;
  assign full_s    = (count_r == CNT_FULL);
  assign wr_en_s   = push_s && (!full_s || pop_s);
  assign ovf_set_s = push_s && full_s && !pop_s;

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {push_ext_s, push_rel_s, keycode_i};
    end
  end

  // Sticky flags and system-byte capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      seq_err_r   <= 1'b0;
      overflow_r  <= 1'b0;
      sys_valid_r <= 1'b0;
      sys_code_r  <= 8'h00;
    end else if (flush_i) begin
      seq_err_r   <= 1'b0;
      overflow_r  <= 1'b0;
      sys_valid_r <= 1'b0;
    end else begin
      seq_err_r   <= seq_err_r || seq_err_set_s;
      overflow_r  <= overflow_r || ovf_set_s;
      sys_valid_r <= sys_hit_s;
      if (sys_hit_s) sys_code_r <= keycode_i;
    end
  end

  assign evt_valid_o = (count_r != '0);
  assign evt_data_o  = evt_valid_o ? mem_r[rd_ptr_r] : 10'h000;
  assign evt_count_o = count_r;
  assign sys_valid_o = sys_valid_r;
  assign sys_code_o  = sys_code_r;
  assign overflow_o  = overflow_r;
  assign seq_err_o   = seq_err_r;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// Self-checking bench for ps2_scancode_ctrl: directed scenarios plus randomized
// byte streams scored against a prefix-flag reference model.
module tb_ps2_scancode_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] keycode_i = 8'h00;
  logic       keycode_valid_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       evt_ready_i = 1'b0;
  logic       evt_valid_o;
  logic [9:0] evt_data_o;
  logic [3:0] evt_count_o;
  logic       sys_valid_o;
  logic [7:0] sys_code_o;
  logic       overflow_o;
  logic       seq_err_o;

  int checks = 0;
  int errors = 0;

  ps2_scancode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .keycode_i(keycode_i), .keycode_valid_i(keycode_valid_i),
    .flush_i(flush_i), .evt_ready_i(evt_ready_i), .evt_valid_o(evt_valid_o),
    .evt_data_o(evt_data_o), .evt_count_o(evt_count_o), .sys_valid_o(sys_valid_o),
    .sys_code_o(sys_code_o), .overflow_o(overflow_o), .seq_err_o(seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending-prefix flags, event queue, sticky flags
  logic [9:0] mq[$];
  bit         m_e0, m_f0, m_serr, m_ovf, m_sysv, m_held;
  logic [7:0] m_sysc;
  logic [8:0] m_last;
  int         m_idle;

  function automatic bit m_is_sys(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE) ||
           (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_e0 = 0; m_f0 = 0; m_serr = 0; m_ovf = 0; m_sysv = 0; m_held = 0;
    m_sysc = 8'h00; m_last = 9'h000; m_idle = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit rdy, input bit fl);
    int sz;
    bit pop, push;
    logic [9:0] ev;
    sz = mq.size();
    pop = (sz > 0) && rdy;
    push = 0;
    ev = 10'h000;
    if (fl) begin
      mq.delete();
      m_e0 = 0; m_f0 = 0; m_serr = 0; m_ovf = 0; m_sysv = 0; m_idle = 0; m_held = 0;
      return;
    end
    m_sysv = 0;
    if (v) begin
      m_idle = 0;
      if (m_is_sys(b)) begin
        m_sysv = 1; m_sysc = b;
        if (m_e0 || m_f0) m_serr = 1;
        m_e0 = 0; m_f0 = 0;
      end else if (b == 8'hE0 || b == 8'hF0) begin
        if (m_f0) begin
          m_serr = 1; m_e0 = 0; m_f0 = 0;
        end else if (b == 8'hE0) m_e0 = 1;
        else m_f0 = 1;
      end else begin
        ev = {m_e0, m_f0, b}; push = 1; m_e0 = 0; m_f0 = 0;
      end
    end else if (m_e0 || m_f0) begin
      if (m_idle == TMO - 1) begin
        m_serr = 1; m_e0 = 0; m_f0 = 0; m_idle = 0;
      end else m_idle++;
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (push) begin
      if (!ev[8]) begin
        if (m_held && {ev[9], ev[7:0]} == m_last) push = 0;
        else begin m_last = {ev[9], ev[7:0]}; m_held = 1; end
      end else if ({ev[9], ev[7:0]} == m_last) m_held = 0;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) mq.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input bit rdy, input bit fl);
    @(negedge clk_i);
    keycode_valid_i = v; keycode_i = b; evt_ready_i = rdy; flush_i = fl;
    model_step(v, b, rdy, fl);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({evt_valid_o, evt_data_o, evt_count_o, sys_valid_o, sys_code_o, overflow_o, seq_err_o} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%0d sv=%b sc=%h ovf=%b err=%b, want all 0",
               evt_valid_o, evt_data_o, evt_count_o, sys_valid_o, sys_code_o, overflow_o, seq_err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_make_break();
    drive(0, 8'h00, 0, 0);
    checks++;
    if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL mb_pre_valid: got %b want 0", evt_valid_o); end
    drive(1, 8'h1C, 0, 0);
    checks++;
    if (evt_valid_o !== 1'b1 || evt_data_o !== 10'h01C) begin
      errors++; $display("FAIL mb_make: got v=%b d=%h want v=1 d=01c", evt_valid_o, evt_data_o);
    end
    drive(1, 8'hF0, 0, 0);
    drive(1, 8'h1C, 0, 0);
    checks++;
    if (evt_count_o !== 4'd2) begin errors++; $display("FAIL mb_count: got %0d want 2", evt_count_o); end
    drive(0, 8'h00, 1, 0);
    checks++;
    if (evt_data_o !== 10'h11C || evt_count_o !== 4'd1) begin
      errors++; $display("FAIL mb_break: got d=%h c=%0d want d=11c c=1", evt_data_o, evt_count_o);
    end
    drive(0, 8'h00, 1, 0);
    checks++;
    if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL mb_drain: got %b want 0", evt_valid_o); end
  endtask

  task automatic test_extended();
    drive(1, 8'hE0, 0, 0); drive(1, 8'h75, 0, 0);
    drive(1, 8'hE0, 0, 0); drive(1, 8'hF0, 0, 0); drive(1, 8'h75, 0, 0);
    checks++;
    if (evt_data_o !== 10'h275 || evt_count_o !== 4'd2 || seq_err_o !== 1'b0) begin
      errors++; $display("FAIL ext_make: got d=%h c=%0d err=%b want 275/2/0", evt_data_o, evt_count_o, seq_err_o);
    end
    drive(0, 8'h00, 1, 0);
    checks++;
    if (evt_data_o !== 10'h375) begin errors++; $display("FAIL ext_break: got %h want 375", evt_data_o); end
    drive(0, 8'h00, 1, 0);
  endtask

  task automatic test_system();
    drive(1, 8'hAA, 0, 0);
    checks++;
    if (sys_valid_o !== 1'b1 || sys_code_o !== 8'hAA || evt_count_o !== 4'd0) begin
      errors++; $display("FAIL sys_bat: got sv=%b sc=%h c=%0d want 1/aa/0", sys_valid_o, sys_code_o, evt_count_o);
    end
    drive(0, 8'h00, 0, 0);
    checks++;
    if (sys_valid_o !== 1'b0 || sys_code_o !== 8'hAA) begin
      errors++; $display("FAIL sys_hold: got sv=%b sc=%h want 0/aa", sys_valid_o, sys_code_o);
    end
    drive(1, 8'hF0, 0, 0); drive(1, 8'hFA, 0, 0);
    checks++;
    if (sys_valid_o !== 1'b1 || sys_code_o !== 8'hFA || seq_err_o !== 1'b1 || evt_count_o !== 4'd0) begin
      errors++; $display("FAIL sys_abort: got sv=%b sc=%h err=%b c=%0d want 1/fa/1/0", sys_valid_o, sys_code_o, seq_err_o, evt_count_o);
    end
    drive(1, 8'h1C, 0, 0);
    checks++;
    if (evt_data_o !== 10'h01C) begin errors++; $display("FAIL sys_after: got %h want 01c", evt_data_o); end
    drive(0, 8'h00, 0, 1);
    checks++;
    if (seq_err_o !== 1'b0 || evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL sys_flush: got err=%b v=%b want 0/0", seq_err_o, evt_valid_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= DEPTH + 1; i++) drive(1, 8'(i), 0, 0);
    checks++;
    if (evt_count_o !== 4'd8 || overflow_o !== 1'b1 || evt_data_o !== 10'h001) begin
      errors++; $display("FAIL ovf_full: got c=%0d ovf=%b d=%h want 8/1/001", evt_count_o, overflow_o, evt_data_o);
    end
    drive(1, 8'h0A, 1, 0);
    checks++;
    if (evt_count_o !== 4'd8 || evt_data_o !== 10'h002) begin
      errors++; $display("FAIL ovf_pushpop: got c=%0d d=%h want 8/002", evt_count_o, evt_data_o);
    end
    for (int i = 0; i < DEPTH - 1; i++) drive(0, 8'h00, 1, 0);
    checks++;
    if (evt_data_o !== 10'h00A || evt_count_o !== 4'd1) begin
      errors++; $display("FAIL ovf_tail: got d=%h c=%0d want 00a/1", evt_data_o, evt_count_o);
    end
    drive(1, 8'h33, 0, 1);
    checks++;
    if (evt_count_o !== 4'd0 || overflow_o !== 1'b0 || evt_valid_o !== 1'b0) begin
      errors++; $display("FAIL ovf_flush: got c=%0d ovf=%b v=%b want 0/0/0", evt_count_o, overflow_o, evt_valid_o);
    end
  endtask

  task automatic test_timeout();
    drive(1, 8'hE0, 0, 0);
    repeat (TMO - 1) drive(0, 8'h00, 0, 0);
    checks++;
    if (seq_err_o !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", seq_err_o); end
    drive(0, 8'h00, 0, 0);
    checks++;
    if (seq_err_o !== 1'b1) begin errors++; $display("FAIL tmo_fire: got %b want 1", seq_err_o); end
    drive(1, 8'h75, 0, 0);
    checks++;
    if (evt_data_o !== 10'h075) begin errors++; $display("FAIL tmo_after: got %h want 075", evt_data_o); end
    drive(0, 8'h00, 0, 1);
    drive(1, 8'hE0, 0, 0);
    repeat (TMO - 1) drive(0, 8'h00, 0, 0);
    drive(1, 8'h75, 0, 0);
    checks++;
    if (evt_data_o !== 10'h275 || seq_err_o !== 1'b0) begin
      errors++; $display("FAIL tmo_bytewins: got d=%h err=%b want 275/0", evt_data_o, seq_err_o);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_reset_mid();
    drive(1, 8'hE0, 0, 0);
    @(negedge clk_i);
    keycode_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 8'h75, 0, 0);
    checks++;
    if (evt_data_o !== 10'h075 || evt_count_o !== 4'd1) begin
      errors++; $display("FAIL rst_mid: got d=%h c=%0d want 075/1", evt_data_o, evt_count_o);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_typematic();
    logic [9:0] exp_q[$];
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_q = '{10'h01C, 10'h11C, 10'h01C};
`else
    exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    drive(1, 8'h1C, 0, 0); drive(1, 8'h1C, 0, 0); drive(1, 8'h1C, 0, 0);
    drive(1, 8'hF0, 0, 0); drive(1, 8'h1C, 0, 0); drive(1, 8'h1C, 0, 0);
    checks++;
    if (int'(evt_count_o) !== exp_q.size()) begin
      errors++; $display("FAIL typ_count: got %0d want %0d", evt_count_o, exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (evt_data_o !== exp_q[i]) begin
        errors++; $display("FAIL typ_event%0d: got %h want %h", i, evt_data_o, exp_q[i]);
      end
      drive(0, 8'h00, 1, 0);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    logic [7:0] sys_tab[7]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
    logic [7:0] make_tab[6] = '{8'h1C, 8'h75, 8'h12, 8'hE1, 8'h5A, 8'h6B};
    bit v, rdy, fl;
    logic [7:0] b;
    int r, vprob;
    for (int c = 0; c < 3000; c++) begin
      vprob = (((c / 150) % 3) == 2) ? 2 : 35;
      v = ($urandom_range(0, 99) < vprob);
      r = $urandom_range(0, 99);
      if (r < 15) b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else if (r < 40) b = sys_tab[$urandom_range(0, 6)];
      else b = make_tab[$urandom_range(0, 5)];
      rdy = ($urandom_range(0, 99) < ((((c / 400) % 2) == 1) ? 10 : 70));
      fl = ($urandom_range(0, 299) == 0);
      drive(v, b, rdy, fl);
      checks++;
      if (evt_valid_o !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, evt_valid_o, mq.size() != 0);
      end
      checks++;
      if (int'(evt_count_o) !== mq.size()) begin
        errors++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, evt_count_o, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (evt_data_o !== mq[0]) begin
          errors++; $display("FAIL rnd_data c=%0d: got %h want %h", c, evt_data_o, mq[0]);
        end
      end
      checks++;
      if (sys_valid_o !== m_sysv || sys_code_o !== m_sysc) begin
        errors++; $display("FAIL rnd_sys c=%0d: got %b/%h want %b/%h", c, sys_valid_o, sys_code_o, m_sysv, m_sysc);
      end
      checks++;
      if (seq_err_o !== m_serr || overflow_o !== m_ovf) begin
        errors++; $display("FAIL rnd_flags c=%0d: got err=%b ovf=%b want %b/%b", c, seq_err_o, overflow_o, m_serr, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_system();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_typematic();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
